mips_mc_control: RTL and testbench

Main control FSM for the MIPS multi-cycle microarchitecture. Sequences the shared datapath (single memory, single ALU, IR/MDR/A/B/ALUOut registers) through fetch, decode, execute, memory and writeback steps per instruction. Decodes the 6-bit opcode from the instruction register and produces all datapath select and enable strobes, plus the combined PC enable. Sits beside the datapath inside `top`; the memory side provides a ready handshake so slow memory stalls the FSM.

---
 rtl/mips_mc_control.sv | 170 +++++++++++++++++
 tb/tb_mips_mc_control.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/mem/writeback and drives datapath strobes.
// Latency: Moore outputs; pc_en is combinational on zero. CPI LW5 SW4 R4 ADDI4 BEQ3 J3 illegal2.
// Backpressure: mem_ready low stalls FETCH, MEMRD and MEMWR with outputs held. MC_CTRL_ADDI_EN enables ADDI.
module mips_mc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        iord,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic        pc_en,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] retired
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_q;
    state_t state_d;
    logic   pc_write;
    logic   branch;
    logic   retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            retired <= 32'd0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired <= retired + 32'd1;
            end
        end
    end

    always_comb begin
        state_d    = FETCH;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_d = ADDIEX;
`endif
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
                state_d   = mem_ready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
                retire    = 1'b1;
            end
`ifdef MC_CTRL_ADDI_EN
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
`endif
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                retire   = 1'b1;
            end
            // Unused encodings recover to FETCH with every strobe low.
            default: state_d = FETCH;
        endcase
    end

    assign pc_en = pc_write | (branch & zero);
    assign state = state_q;

    // OP_ADDI is referenced only in the ADDI build; keep it visible to lint in both.
    logic unused_addi;
    assign unused_addi = ^OP_ADDI;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed-vector bench for mips_mc_control; expected state/strobe vectors are hand-computed per cycle.
module tb_mips_mc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic        pc_en, illegal;
    logic [3:0]  state;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;

    mips_mc_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .pc_en(pc_en),
        .illegal(illegal), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    // {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal}
    logic [14:0] ctl;
    assign ctl = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                  alu_src_b, alu_op, pc_src, pc_en, illegal};

    localparam logic [14:0] C_F0   = 15'b0_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [14:0] C_F1   = 15'b0_0_1_0_0_0_0_01_00_00_1_0;
    localparam logic [14:0] C_DEC  = 15'b0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [14:0] C_ILL  = 15'b0_0_0_0_0_0_0_11_00_00_0_1;
    localparam logic [14:0] C_MADR = 15'b0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [14:0] C_MRD  = 15'b1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [14:0] C_MWB  = 15'b0_0_0_0_1_1_0_00_00_00_0_0;
    localparam logic [14:0] C_MWR  = 15'b1_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [14:0] C_EXE  = 15'b0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [14:0] C_AWB  = 15'b0_0_0_1_0_1_0_00_00_00_0_0;
    localparam logic [14:0] C_BRT  = 15'b0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [14:0] C_BRN  = 15'b0_0_0_0_0_0_1_00_01_01_0_0;
    localparam logic [14:0] C_JMP  = 15'b0_0_0_0_0_0_0_00_00_10_1_0;
    localparam logic [14:0] C_IWB  = 15'b0_0_0_0_0_1_0_00_00_00_0_0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Sample on the falling edge, then advance past the next rising edge.
    task automatic cyc(input string tag, input logic [3:0] es, input logic [14:0] ec);
        @(negedge clk);
        check({tag, "_state"}, {28'd0, state}, {28'd0, es});
        check({tag, "_ctl"}, {17'd0, ctl}, {17'd0, ec});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        opcode = 6'b000000;
        zero = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, FETCH stalled
        @(negedge clk);
        check("rst_retired", retired, 32'd0);
        cyc("rst", 4'd0, C_F0);

        // LW, no stalls: 0,1,2,3,4,0
        mem_ready = 1'b1;
        opcode = 6'b100011;
        cyc("lw_f", 4'd0, C_F1);
        cyc("lw_d", 4'd1, C_DEC);
        cyc("lw_a", 4'd2, C_MADR);
        cyc("lw_r", 4'd3, C_MRD);
        cyc("lw_w", 4'd4, C_MWB);
        check("lw_retired", retired, 32'd1);

        // SW with three MEMWR stall cycles: 7 cycles total
        opcode = 6'b101011;
        cyc("sw_f", 4'd0, C_F1);
        cyc("sw_d", 4'd1, C_DEC);
        cyc("sw_a", 4'd2, C_MADR);
        mem_ready = 1'b0;
        cyc("sw_s0", 4'd5, C_MWR);
        cyc("sw_s1", 4'd5, C_MWR);
        check("sw_ret_stall", retired, 32'd1);
        cyc("sw_s2", 4'd5, C_MWR);
        mem_ready = 1'b1;
        cyc("sw_w", 4'd5, C_MWR);
        check("sw_retired", retired, 32'd2);

        // BEQ taken then not taken
        opcode = 6'b000100;
        zero = 1'b1;
        cyc("beqt_f", 4'd0, C_F1);
        cyc("beqt_d", 4'd1, C_DEC);
        cyc("beqt_b", 4'd8, C_BRT);
        zero = 1'b0;
        cyc("beqn_f", 4'd0, C_F1);
        cyc("beqn_d", 4'd1, C_DEC);
        cyc("beqn_b", 4'd8, C_BRN);
        check("beq_retired", retired, 32'd4);

        // LW with one MEMRD stall
        opcode = 6'b100011;
        cyc("lw2_f", 4'd0, C_F1);
        cyc("lw2_d", 4'd1, C_DEC);
        cyc("lw2_a", 4'd2, C_MADR);
        mem_ready = 1'b0;
        cyc("lw2_s", 4'd3, C_MRD);
        mem_ready = 1'b1;
        cyc("lw2_r", 4'd3, C_MRD);
        cyc("lw2_w", 4'd4, C_MWB);
        check("lw2_retired", retired, 32'd5);

        // J
        opcode = 6'b000010;
        cyc("j_f", 4'd0, C_F1);
        cyc("j_d", 4'd1, C_DEC);
        cyc("j_j", 4'd11, C_JMP);
        check("j_retired", retired, 32'd6);

        // Illegal opcode: single-cycle pulse, no retire
        opcode = 6'b111111;
        cyc("ill_f", 4'd0, C_F1);
        cyc("ill_d", 4'd1, C_ILL);
        opcode = 6'b000000;
        cyc("ill_after", 4'd0, C_F1);
        check("ill_retired", retired, 32'd6);

        // R-type (fetch already done above)
        cyc("r_d", 4'd1, C_DEC);
        cyc("r_e", 4'd6, C_EXE);
        cyc("r_w", 4'd7, C_AWB);
        check("r_retired", retired, 32'd7);

        // Reset in EXECUTE abandons the R-type
        cyc("rr_f", 4'd0, C_F1);
        cyc("rr_d", 4'd1, C_DEC);
        @(negedge clk);
        check("rr_exec", {28'd0, state}, 32'd6);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rr_retired", retired, 32'd0);
        cyc("rr_after", 4'd0, C_F1);

        // ADDI
        opcode = 6'b001000;
`ifdef MC_CTRL_ADDI_EN
        cyc("addi_d", 4'd1, C_DEC);
        cyc("addi_e", 4'd9, C_MADR);
        cyc("addi_w", 4'd10, C_IWB);
        check("addi_retired", retired, 32'd1);
`else
        cyc("addi_d", 4'd1, C_ILL);
        cyc("addi_after", 4'd0, C_F1);
        check("addi_retired", retired, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
